// File: rtl/note_entry.sv
// note_entry: debounced "confirm note" button front end for the word recognizer.
//   Synchronizes btn/tone_sw/note_sw, debounces btn, and emits one ok pulse per
//   accepted press with the tone/note captured on that same edge.
// Ports:
//   clk, reset    - system clock, synchronous active-high reset
//   btn           - raw bouncing push-button (active-high)
//   tone_sw       - raw tone switch (1 = sharp/upper)
//   note_sw[2:0]  - raw note selector (000 = rest/end, 001..111 = C..B)
//   ok            - one-cycle pulse per accepted press
//   tone, note    - values captured with the latest ok, held between pulses
//   busy          - debounce machine active (btn_s level when debounce is off)
//   count[3:0]    - accepted presses since reset, saturating at 15
// Build option: define NOTE_ENTRY_DEBOUNCE_EN for the counter-based debounce
// FSM; otherwise ok fires on each synchronized rising edge of btn.
module note_entry #(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn,
   input  logic       tone_sw,
   input  logic [2:0] note_sw,
   output logic       ok,
   output logic       tone,
   output logic [2:0] note,
   output logic       busy,
   output logic [3:0] count
);

   // Two-flop synchronizers for all raw inputs.
   logic       btn_m, btn_s;
   logic       tone_m, tone_s;
   logic [2:0] note_m, note_s;

   always_ff @(posedge clk) begin
      if (reset) begin
         btn_m  <= 1'b0;
         btn_s  <= 1'b0;
         tone_m <= 1'b0;
         tone_s <= 1'b0;
         note_m <= 3'b000;
         note_s <= 3'b000;
      end else begin
         btn_m  <= btn;
         btn_s  <= btn_m;
         tone_m <= tone_sw;
         tone_s <= tone_m;
         note_m <= note_sw;
         note_s <= note_m;
      end
   end

   // press is high in the cycle before ok: the edge that raises ok also
   // captures tone/note and bumps count.
   logic press;

`ifdef NOTE_ENTRY_DEBOUNCE_EN
   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_t;

   localparam logic [15:0] LIMIT    = 16'(DEBOUNCE_CYCLES);
   localparam logic [15:0] LIMIT_M1 = 16'(DEBOUNCE_CYCLES - 1);

   state_t      state, state_nxt;
   logic [15:0] cnt, cnt_nxt;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= 16'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (btn_s) begin
               state_nxt = PRESS_WAIT;
               cnt_nxt   = 16'd1;
            end else begin
               cnt_nxt = 16'd0;
            end
         end
         PRESS_WAIT: begin
            if (!btn_s) begin
               state_nxt = IDLE;
               cnt_nxt   = 16'd0;
            end else if (cnt >= LIMIT) begin
               state_nxt = PRESSED;
               cnt_nxt   = 16'd0;
            end else begin
               cnt_nxt = cnt + 16'd1;
            end
         end
         PRESSED: begin
            state_nxt = RELEASE_WAIT;
            cnt_nxt   = 16'd0;
         end
         RELEASE_WAIT: begin
            // Any high sample restarts the release window; the edge whose
            // increment would reach the limit returns to IDLE instead.
            if (btn_s) begin
               cnt_nxt = 16'd0;
            end else if (cnt >= LIMIT_M1) begin
               state_nxt = IDLE;
               cnt_nxt   = 16'd0;
            end else begin
               cnt_nxt = cnt + 16'd1;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = 16'd0;
         end
      endcase
   end

   assign press = (state_nxt == PRESSED);
   assign busy  = (state != IDLE);
`else
   // Two extra stages delay edge detection so ok lands one cycle after
   // edge 3 of the first high sample of btn.
   logic btn_d, btn_d2;

   always_ff @(posedge clk) begin
      if (reset) begin
         btn_d  <= 1'b0;
         btn_d2 <= 1'b0;
      end else begin
         btn_d  <= btn_s;
         btn_d2 <= btn_d;
      end
   end

   assign press = btn_d & ~btn_d2;
   assign busy  = btn_s;
`endif

   // Registered outputs shared by both builds.
   always_ff @(posedge clk) begin
      if (reset) begin
         ok    <= 1'b0;
         tone  <= 1'b0;
         note  <= 3'b000;
         count <= 4'd0;
      end else begin
         ok <= press;
         if (press) begin
            tone <= tone_s;
            note <= note_s;
            if (count != 4'd15) begin
               count <= count + 4'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_note_entry.sv
module tb_note_entry;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       btn = 1'b0;
   logic       tone_sw = 1'b0;
   logic [2:0] note_sw = 3'b000;
   logic       ok, tone, busy;
   logic [2:0] note;
   logic [3:0] count;

   int n_chk  = 0;
   int n_fail = 0;

   note_entry #(.DEBOUNCE_CYCLES(4)) dut (
      .clk     (clk),
      .reset   (reset),
      .btn     (btn),
      .tone_sw (tone_sw),
      .note_sw (note_sw),
      .ok      (ok),
      .tone    (tone),
      .note    (note),
      .busy    (busy),
      .count   (count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      btn   = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Run n cycles, counting ok pulses and capturing note/tone at the last one.
   task automatic run(input int n, output int pulses, output int p_note, output int p_tone);
      pulses = 0;
      p_note = -1;
      p_tone = -1;
      for (int i = 0; i < n; i++) begin
         tick();
         if (ok) begin
            pulses++;
            p_note = int'(note);
            p_tone = int'(tone);
         end
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_ok"},    int'(ok),    0);
      check({tag, "_tone"},  int'(tone),  0);
      check({tag, "_note"},  int'(note),  0);
      check({tag, "_busy"},  int'(busy),  0);
      check({tag, "_count"}, int'(count), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, observed running, expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int p, pn, pt, total;
`ifdef NOTE_ENTRY_DEBOUNCE_EN
      logic [2:0] nt [5];
      logic       tn [5];
      nt = '{3'b100, 3'b001, 3'b010, 3'b101, 3'b000};
      tn = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

      // Reset values, then held press with latency 2+4.
      do_reset();
      check_reset_vals("rst");
      note_sw = 3'b100;
      tone_sw = 1'b0;
      btn     = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check($sformatf("lat_ok_e%0d", i), int'(ok), (i == 6) ? 1 : 0);
         if (i == 1) check("lat_busy_e1", int'(busy), 0);
         if (i == 2) check("lat_busy_e2", int'(busy), 1);
         if (i == 6) begin
            check("lat_note", int'(note), 4);
            check("lat_tone", int'(tone), 0);
            check("lat_count", int'(count), 1);
         end
      end
      btn = 1'b0;
      run(10, p, pn, pt);
      check("lat_rel_pulses", p, 0);
      check("lat_rel_busy", int'(busy), 0);

      // Short glitches never qualify.
      do_reset();
      note_sw = 3'b101;
      total = 0;
      for (int i = 0; i < 17; i++) begin
         btn = ((i < 3) || (i >= 4 && i < 7)) ? 1'b1 : 1'b0;
         tick();
         if (ok) total++;
      end
      check("glitch_pulses", total, 0);
      check("glitch_count", int'(count), 0);
      check("glitch_note", int'(note), 0);

      // Five clean presses: F, C#, D, G, x.
      do_reset();
      for (int k = 0; k < 5; k++) begin
         note_sw = nt[k];
         tone_sw = tn[k];
         btn     = 1'b1;
         run(10, p, pn, pt);
         check($sformatf("seq%0d_pulses", k), p, 1);
         check($sformatf("seq%0d_note", k), pn, int'(nt[k]));
         check($sformatf("seq%0d_tone", k), pt, int'(tn[k]));
         btn = 1'b0;
         run(10, p, pn, pt);
         check($sformatf("seq%0d_rel_pulses", k), p, 0);
      end
      check("seq_count", int'(count), 5);

      // Note change while held, then bouncing release.
      do_reset();
      note_sw = 3'b011;
      tone_sw = 1'b1;
      btn     = 1'b1;
      run(8, p, pn, pt);
      check("hold_pulses", p, 1);
      check("hold_note_cap", pn, 3);
      note_sw = 3'b110;
      tone_sw = 1'b0;
      run(5, p, pn, pt);
      check("hold_extra_pulses", p, 0);
      check("hold_note", int'(note), 3);
      check("hold_tone", int'(tone), 1);
      for (int j = 0; j < 10; j++) begin
         btn = (j == 2) ? 1'b1 : 1'b0;
         tick();
         if (ok) check("bounce_no_ok", 1, 0);
         if (j >= 5 && j <= 7) check($sformatf("bounce_busy_j%0d", j), int'(busy), 1);
         if (j == 8) check("bounce_idle_j8", int'(busy), 0);
      end
      btn = 1'b1;
      run(10, p, pn, pt);
      check("next_pulses", p, 1);
      check("next_note", pn, 6);
      check("next_tone", pt, 0);
      btn = 1'b0;
      run(10, p, pn, pt);

      // Reset during PRESS_WAIT, then held button is a fresh press.
      do_reset();
      note_sw = 3'b111;
      tone_sw = 1'b1;
      btn     = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      check("mid_busy", int'(busy), 1);
      reset = 1'b1;
      tick();
      check_reset_vals("mid_rst");
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         check($sformatf("post_rst_ok_e%0d", i), int'(ok), (i == 6) ? 1 : 0);
         if (i == 6) check("post_rst_note", int'(note), 7);
      end
      btn = 1'b0;
      run(10, p, pn, pt);
`else
      // Edge-detect build: ok one cycle after edge 3.
      do_reset();
      check_reset_vals("rst");
      note_sw = 3'b010;
      tone_sw = 1'b1;
      btn     = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         check($sformatf("nd_ok_e%0d", i), int'(ok), (i == 3) ? 1 : 0);
         if (i == 0) check("nd_busy_e0", int'(busy), 0);
         if (i == 1) check("nd_busy_e1", int'(busy), 1);
         if (i == 3) begin
            check("nd_note", int'(note), 2);
            check("nd_tone", int'(tone), 1);
            check("nd_count", int'(count), 1);
         end
      end
      note_sw = 3'b101;
      tone_sw = 1'b0;
      run(4, p, pn, pt);
      check("nd_hold_pulses", p, 0);
      check("nd_hold_note", int'(note), 2);
      check("nd_hold_tone", int'(tone), 1);
      btn = 1'b0;
      run(4, p, pn, pt);
      check("nd_rel_busy", int'(busy), 0);

      // Twenty presses saturate count at 15.
      do_reset();
      total = 0;
      for (int k = 0; k < 20; k++) begin
         btn = 1'b1;
         run(4, p, pn, pt);
         total += p;
         btn = 1'b0;
         run(4, p, pn, pt);
         total += p;
         if (k == 13) check("sat_count14", int'(count), 14);
         if (k == 14) check("sat_count15", int'(count), 15);
      end
      check("sat_pulses", total, 20);
      check("sat_count_final", int'(count), 15);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
